// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a stall counter.
// Optional macro FWD_EN: forwarding present, so only load-use stalls; undefined stalls on any RAW.
module idex_hazard_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_in,
  input  logic        valid_in,
  input  logic        rs_used_in,
  input  logic        rt_used_in,
  input  logic        reg_wrt_in,
  input  logic        mem_read_in,
  input  logic        mem_wrt_in,
  input  logic [2:0]  target_in,
  input  logic [4:0]  alu_op_in,
  input  logic [1:0]  alu_src_in,
  input  logic [15:0] rs_data_in,
  input  logic [15:0] rt_data_in,
  input  logic [15:0] imm_in,
  input  logic        flush,
  input  logic        mem_stall,
  output logic        stall_out,
  output logic [15:0] instr_reg,
  output logic        valid_reg,
  output logic        Reg_wrt_reg,
  output logic        Mem_read_reg,
  output logic        Mem_wrt_reg,
  output logic [2:0]  target_reg,
  output logic [4:0]  alu_op_reg,
  output logic [1:0]  alu_src_reg,
  output logic [15:0] rs_data_reg,
  output logic [15:0] rt_data_reg,
  output logic [15:0] imm_reg,
  output logic        fwd_possible_reg,
  output logic [15:0] stall_cycles
);

  localparam logic [15:0] NopInstr = 16'h0800;

  typedef struct packed {
    logic [15:0] instr;
    logic        valid;
    logic        reg_wrt;
    logic        mem_read;
    logic        mem_wrt;
    logic [2:0]  target;
    logic [4:0]  alu_op;
    logic [1:0]  alu_src;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
  } ex_entry_t;

  // instr is the most significant field, so the NOP word lands in the top 16 bits.
  localparam ex_entry_t BubbleEntry =
      ex_entry_t'({NopInstr, {($bits(ex_entry_t) - 16){1'b0}}});

  ex_entry_t   ex_q, ex_d;
  logic        sh_valid_q, sh_valid_d;
  logic        sh_wrt_q, sh_wrt_d;
  logic [2:0]  sh_target_q, sh_target_d;
  logic [15:0] cnt_q, cnt_d;

  logic [2:0]  rs_idx, rt_idx;
  logic        hit_ex, hit_mem, hazard;
  ex_entry_t   in_entry;

  assign rs_idx = instr_in[10:8];
  assign rt_idx = instr_in[7:5];

  assign hit_ex = valid_in & ((rs_used_in & (rs_idx == ex_q.target)) |
                              (rt_used_in & (rt_idx == ex_q.target)));
  assign hit_mem = valid_in & ((rs_used_in & (rs_idx == sh_target_q)) |
                               (rt_used_in & (rt_idx == sh_target_q)));

`ifdef FWD_EN
  assign hazard = ex_q.valid & ex_q.reg_wrt & ex_q.mem_read & hit_ex;
`else
  assign hazard = (ex_q.valid & ex_q.reg_wrt & hit_ex) |
                  (sh_valid_q & sh_wrt_q & hit_mem);
`endif

  assign stall_out = rst_n & (mem_stall | (~flush & hazard));

  always_comb begin
    in_entry          = BubbleEntry;
    in_entry.instr    = instr_in;
    in_entry.valid    = 1'b1;
    in_entry.reg_wrt  = reg_wrt_in;
    in_entry.mem_read = mem_read_in;
    in_entry.mem_wrt  = mem_wrt_in;
    in_entry.target   = target_in;
    in_entry.alu_op   = alu_op_in;
    in_entry.alu_src  = alu_src_in;
    in_entry.rs_data  = rs_data_in;
    in_entry.rt_data  = rt_data_in;
    in_entry.imm      = imm_in;
  end

  always_comb begin
    ex_d        = ex_q;
    sh_valid_d  = sh_valid_q;
    sh_wrt_d    = sh_wrt_q;
    sh_target_d = sh_target_q;
    cnt_d       = cnt_q;
    if (!mem_stall) begin
      sh_valid_d  = ex_q.valid;
      sh_wrt_d    = ex_q.reg_wrt;
      sh_target_d = ex_q.target;
      if (flush) begin
        ex_d = BubbleEntry;
      end else if (hazard) begin
        ex_d = BubbleEntry;
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end else if (valid_in) begin
        ex_d = in_entry;
      end else begin
        ex_d = BubbleEntry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= BubbleEntry;
      sh_valid_q  <= 1'b0;
      sh_wrt_q    <= 1'b0;
      sh_target_q <= 3'd0;
      cnt_q       <= 16'd0;
    end else begin
      ex_q        <= ex_d;
      sh_valid_q  <= sh_valid_d;
      sh_wrt_q    <= sh_wrt_d;
      sh_target_q <= sh_target_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef FWD_EN
  logic fwd_q, fwd_d;

  // A freshly issued valid entry is forwardable; bubbles never are.
  always_comb begin
    fwd_d = fwd_q;
    if (!mem_stall) begin
      fwd_d = ~flush & ~hazard & valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_q <= 1'b0;
    end else begin
      fwd_q <= fwd_d;
    end
  end

  assign fwd_possible_reg = fwd_q;
`else
  assign fwd_possible_reg = 1'b0;
`endif

  assign instr_reg    = ex_q.instr;
  assign valid_reg    = ex_q.valid;
  assign Reg_wrt_reg  = ex_q.reg_wrt;
  assign Mem_read_reg = ex_q.mem_read;
  assign Mem_wrt_reg  = ex_q.mem_wrt;
  assign target_reg   = ex_q.target;
  assign alu_op_reg   = ex_q.alu_op;
  assign alu_src_reg  = ex_q.alu_src;
  assign rs_data_reg  = ex_q.rs_data;
  assign rt_data_reg  = ex_q.rt_data;
  assign imm_reg      = ex_q.imm;
  assign stall_cycles = cnt_q;

endmodule
